// File: rtl/cnn_layer_accel_job_sequencer.sv
// Job sequencer for one cnn_layer_accel_quad layer job: streams config words
// from the config memory, launches the job, answers each row fetch with one
// row of pixel words from the pixel memory, then acknowledges job completion.
module cnn_layer_accel_job_sequencer #(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_CFG_AW     = 10,
  parameter int C_PIX_AW     = 16
) (
  input  logic                    clk_if,
  input  logic                    rst,
  input  logic                    host_start,
  input  logic [C_CFG_AW-1:0]     num_cfg_words,
  input  logic [9:0]              num_rows,
  input  logic [9:0]              num_cols,
  output logic                    host_busy,
  output logic                    host_done,
  output logic                    host_err,
  output logic                    cfg_rd_en,
  output logic [C_CFG_AW-1:0]     cfg_rd_addr,
  input  logic [C_DATA_WIDTH-1:0] cfg_rd_data,
  output logic                    pix_rd_en,
  output logic [C_PIX_AW-1:0]     pix_rd_addr,
  input  logic [C_DATA_WIDTH-1:0] pix_rd_data,
  output logic                    config_valid,
  input  logic                    config_accept,
  output logic [C_DATA_WIDTH-1:0] config_data,
  output logic                    job_start,
  input  logic                    job_accept,
  input  logic                    job_fetch_request,
  output logic                    job_fetch_ack,
  output logic                    job_fetch_complete,
  input  logic                    job_complete,
  output logic                    job_complete_ack,
  output logic                    pixel_valid,
  input  logic                    pixel_ready,
  output logic [C_DATA_WIDTH-1:0] pixel_data
);

  localparam int CNT_W = (C_CFG_AW > 10) ? C_CFG_AW : 10;
  localparam logic [CNT_W-1:0]    CNT_ONE = 1;
  localparam logic [C_PIX_AW-1:0] PIX_ONE = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_START,
    S_WAIT_FETCH,
    S_FETCH_ACK,
    S_STREAM,
    S_FETCH_DONE,
    S_WAIT_CMPL,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [C_CFG_AW-1:0] num_cfg_q, num_cfg_d;
  logic [9:0]          num_rows_q, num_rows_d;
  logic [9:0]          num_cols_q, num_cols_d;
  logic [9:0]          row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;   // reads issued in the current phase
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;   // words handed to the quad in the current phase
  logic [C_PIX_AW-1:0] pix_addr_q, pix_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rd_pend_q, rd_pend_d; // a read was issued last cycle; its data is on the bus now
  logic [1:0]          occ_q, occ_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [C_DATA_WIDTH-1:0] fifo_q [2];
  logic [C_DATA_WIDTH-1:0] fifo_d [2];

  logic                    is_cfg, is_stream, in_xfer;
  logic                    fifo_pop, rd_issue, last_xfer;
  logic [CNT_W-1:0]        phase_len;
  logic [2:0]              slots_used;
  logic [C_DATA_WIDTH-1:0] fifo_head, push_data;

  // Config and pixel phases share one 2-entry FIFO and one read/transfer scheme.
  assign is_cfg     = (state_q == S_CFG);
  assign is_stream  = (state_q == S_STREAM);
  assign in_xfer    = is_cfg || is_stream;
  assign phase_len  = is_cfg ? CNT_W'(num_cfg_q) : CNT_W'(num_cols_q);
  assign fifo_head  = fifo_q[rd_ptr_q];
  assign push_data  = is_cfg ? cfg_rd_data : pix_rd_data;
  assign fifo_pop   = in_xfer && (occ_q != 2'd0) && (is_cfg ? config_accept : pixel_ready);
  // Counting this cycle's pop lets a read issue every cycle while the consumer keeps up.
  assign slots_used = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, fifo_pop};
  assign rd_issue   = in_xfer && (rd_cnt_q < phase_len) && (slots_used < 3'd2);
  assign last_xfer  = fifo_pop && (tx_cnt_q == phase_len - CNT_ONE);

  assign config_valid = is_cfg && (occ_q != 2'd0);
  assign pixel_valid  = is_stream && (occ_q != 2'd0);
  assign config_data  = config_valid ? fifo_head : '0;
  assign pixel_data   = pixel_valid ? fifo_head : '0;
  assign cfg_rd_addr  = is_cfg ? rd_cnt_q[C_CFG_AW-1:0] : '0;
  assign pix_rd_addr  = pix_addr_q;
  assign host_busy    = busy_q;
  assign host_done    = done_q;
  assign host_err     = done_q && err_q;

  // Control state, counters and FIFO bookkeeping registers.
  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_cfg_q  <= '0;
      num_rows_q <= '0;
      num_cols_q <= '0;
      row_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      pix_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      occ_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      num_cfg_q  <= num_cfg_d;
      num_rows_q <= num_rows_d;
      num_cols_q <= num_cols_d;
      row_cnt_q  <= row_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      pix_addr_q <= pix_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_pend_q  <= rd_pend_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; flushing is done by the pointers and occupancy above.
  // NOTE: data storage has no reset; outputs are gated by valid, so stale words never leave the block.
  always_ff @(posedge clk_if) begin
    fifo_q <= fifo_d;
  end

  // Next-state, counter and handshake logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d            = state_q;
    num_cfg_d          = num_cfg_q;
    num_rows_d         = num_rows_q;
    num_cols_d         = num_cols_q;
    row_cnt_d          = row_cnt_q;
    rd_cnt_d           = rd_cnt_q;
    tx_cnt_d           = tx_cnt_q;
    pix_addr_d         = pix_addr_q;
    busy_d             = busy_q;
    done_d             = 1'b0;
    err_d              = err_q;
    fifo_d             = fifo_q;
    wr_ptr_d           = wr_ptr_q;
    rd_ptr_d           = rd_ptr_q;
    occ_d              = occ_q + {1'b0, rd_pend_q} - {1'b0, fifo_pop};
    rd_pend_d          = rd_issue;
    cfg_rd_en          = 1'b0;
    pix_rd_en          = 1'b0;
    job_start          = 1'b0;
    job_fetch_ack      = 1'b0;
    job_fetch_complete = 1'b0;
    job_complete_ack   = 1'b0;

    // busy drops the cycle after the done pulse
    if (done_q) busy_d = 1'b0;

    if (rd_pend_q) begin
      fifo_d[wr_ptr_q] = push_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (fifo_pop) rd_ptr_d = ~rd_ptr_q;
    if (rd_issue) rd_cnt_d = rd_cnt_q + CNT_ONE;
    if (fifo_pop) tx_cnt_d = tx_cnt_q + CNT_ONE;

    case (state_q)
      S_IDLE: begin
        if (host_start && !busy_q) begin
          num_cfg_d  = num_cfg_words;
          num_rows_d = num_rows;
          num_cols_d = num_cols;
          row_cnt_d  = '0;
          rd_cnt_d   = '0;
          tx_cnt_d   = '0;
          pix_addr_d = '0;
          busy_d     = 1'b1;
          err_d      = (num_cfg_words == '0) || (num_rows == 10'd0) || (num_cols == 10'd0);
          state_d    = err_d ? S_DONE : S_CFG;
        end
      end
      S_CFG: begin
        cfg_rd_en = rd_issue;
        if (last_xfer) begin
          rd_cnt_d = '0;
          tx_cnt_d = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        job_start = 1'b1;
        if (job_accept) state_d = S_WAIT_FETCH;
      end
      S_WAIT_FETCH: begin
        if (job_fetch_request) state_d = S_FETCH_ACK;
      end
      S_FETCH_ACK: begin
        job_fetch_ack = 1'b1;
        state_d       = S_STREAM;
      end
      S_STREAM: begin
        pix_rd_en = rd_issue;
        // running address across rows: row r starts at r*num_cols without a multiplier
        if (rd_issue) pix_addr_d = pix_addr_q + PIX_ONE;
        if (last_xfer) begin
          rd_cnt_d = '0;
          tx_cnt_d = '0;
          state_d  = S_FETCH_DONE;
        end
      end
      S_FETCH_DONE: begin
        job_fetch_complete = 1'b1;
        row_cnt_d          = row_cnt_q + 10'd1;
        state_d            = (row_cnt_d == num_rows_q) ? S_WAIT_CMPL : S_WAIT_FETCH;
      end
      S_WAIT_CMPL: begin
        if (job_complete) begin
          job_complete_ack = 1'b1;
          state_d          = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cnn_layer_accel_job_sequencer.sv
// Self-checking bench for the job sequencer: memories and a quad responder
// around the DUT, a monitor that records every transfer, and a reference
// expectation built from the memory contents and the job counts.
`timescale 1ns/1ps
module tb_cnn_layer_accel_job_sequencer;

  localparam int DW  = 128;
  localparam int CAW = 10;
  localparam int PAW = 16;
  typedef logic [319:0] vec_t;

  logic           clk_if = 1'b0;
  logic           rst = 1'b1;
  logic           host_start = 1'b0;
  logic [CAW-1:0] num_cfg_words = '0;
  logic [9:0]     num_rows = '0;
  logic [9:0]     num_cols = '0;
  logic           host_busy, host_done, host_err;
  logic           cfg_rd_en, pix_rd_en;
  logic [CAW-1:0] cfg_rd_addr;
  logic [PAW-1:0] pix_rd_addr;
  logic [DW-1:0]  cfg_rd_data = '0;
  logic [DW-1:0]  pix_rd_data = '0;
  logic           config_valid, job_start, job_fetch_ack, job_fetch_complete, job_complete_ack, pixel_valid;
  logic [DW-1:0]  config_data, pixel_data;
  logic           config_accept = 1'b1;
  logic           job_accept = 1'b1;
  logic           job_fetch_request = 1'b1;
  logic           job_complete = 1'b0;
  logic           pixel_ready = 1'b1;

  cnn_layer_accel_job_sequencer #(.C_DATA_WIDTH(DW), .C_CFG_AW(CAW), .C_PIX_AW(PAW)) dut (
    .clk_if(clk_if), .rst(rst), .host_start(host_start),
    .num_cfg_words(num_cfg_words), .num_rows(num_rows), .num_cols(num_cols),
    .host_busy(host_busy), .host_done(host_done), .host_err(host_err),
    .cfg_rd_en(cfg_rd_en), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data),
    .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
    .config_valid(config_valid), .config_accept(config_accept), .config_data(config_data),
    .job_start(job_start), .job_accept(job_accept),
    .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
    .job_fetch_complete(job_fetch_complete),
    .job_complete(job_complete), .job_complete_ack(job_complete_ack),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_data(pixel_data)
  );

  always #5 clk_if = ~clk_if;

  // every DUT output, 293 bits, zero-padded
  vec_t all_out;
  assign all_out = {27'b0, host_busy, host_done, host_err, cfg_rd_en, cfg_rd_addr,
                    pix_rd_en, pix_rd_addr, config_valid, config_data,
                    job_start, job_fetch_ack, job_fetch_complete, job_complete_ack,
                    pixel_valid, pixel_data};

  // local memories with one cycle of read latency
  logic [DW-1:0] cfg_mem [1024];
  logic [DW-1:0] pix_mem [256];
  always @(posedge clk_if) begin
    if (cfg_rd_en) cfg_rd_data <= cfg_mem[cfg_rd_addr];
    if (pix_rd_en) pix_rd_data <= pix_mem[pix_rd_addr[7:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  int            cyc = 0;
  int            cfg_addr_q[$];
  int            pix_addr_q[$];
  logic [DW-1:0] cfg_dat_q[$];
  logic [DW-1:0] pix_dat_q[$];
  int            n_start, n_fack, n_fcmpl, n_cack, n_done, n_err, n_cfg_valid;
  int            cfg_first, cfg_last, last_fcmpl_cyc;
  int            exp_rows, exp_cols;
  logic          cfg_stall = 1'b0, pix_stall = 1'b0;
  logic [DW-1:0] cfg_hold, pix_hold;
  logic [3:0]    hs;

  task automatic clear_mon();
    cfg_addr_q.delete(); pix_addr_q.delete(); cfg_dat_q.delete(); pix_dat_q.delete();
    n_start = 0; n_fack = 0; n_fcmpl = 0; n_cack = 0; n_done = 0; n_err = 0; n_cfg_valid = 0;
    cfg_first = 0; cfg_last = 0; last_fcmpl_cyc = 0;
  endtask

  always @(negedge clk_if) begin
    if (rst) begin
      cfg_stall = 1'b0;
      pix_stall = 1'b0;
    end else begin
      cyc++;
      if (cfg_stall) check("cfg_hold", vec_t'({config_valid, config_data}), vec_t'({1'b1, cfg_hold}));
      if (pix_stall) check("pix_hold", vec_t'({pixel_valid, pixel_data}), vec_t'({1'b1, pix_hold}));
      cfg_stall = config_valid && !config_accept;
      cfg_hold  = config_data;
      pix_stall = pixel_valid && !pixel_ready;
      pix_hold  = pixel_data;
      if (cfg_rd_en) cfg_addr_q.push_back(int'(cfg_rd_addr));
      if (pix_rd_en) pix_addr_q.push_back(int'(pix_rd_addr));
      if (config_valid) n_cfg_valid++;
      if (config_valid && config_accept) begin
        if (cfg_dat_q.size() == 0) cfg_first = cyc;
        cfg_last = cyc;
        cfg_dat_q.push_back(config_data);
      end
      if (pixel_valid && pixel_ready) pix_dat_q.push_back(pixel_data);
      hs = {job_start, job_fetch_ack, job_fetch_complete, job_complete_ack};
      if (hs != 4'b0) check("hs_onehot", vec_t'($countones(hs)), vec_t'(1));
      if (job_start) n_start++;
      if (job_fetch_ack) n_fack++;
      if (job_fetch_complete) begin
        check("fcmpl_after_row", vec_t'(pix_dat_q.size()), vec_t'((n_fcmpl + 1) * exp_cols));
        n_fcmpl++;
        last_fcmpl_cyc = cyc;
      end
      if (job_complete_ack) begin
        check("cack_rows", vec_t'(n_fcmpl), vec_t'(exp_rows));
        check("cack_delay", vec_t'(cyc - last_fcmpl_cyc), vec_t'(1));
        n_cack++;
      end
      if (host_done) begin
        n_done++;
        if (host_err) n_err++;
      end
    end
  end

  // ---------------- accept/ready drivers ----------------
  int acc_mode = 0;   // 0: always 1, 1: random 50%
  int pix_mode = 0;   // 0: always 1, 1: 5-cycle stall at word 23, 2: random 50%
  int stall_left = 0;
  bit stall_done = 1'b0;
  initial begin
    forever begin
      @(posedge clk_if); #2;
      config_accept = (acc_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (pix_mode == 1 && pix_dat_q.size() == 23 && !stall_done) begin
        stall_left = 5;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        pixel_ready = 1'b0;
        stall_left--;
      end else if (pix_mode == 2) begin
        pixel_ready = ($urandom_range(0, 1) == 1);
      end else begin
        pixel_ready = 1'b1;
      end
    end
  end

  // ---------------- job helpers ----------------
  task automatic start_job(input int ncfg, input int nrows, input int ncols,
                           input int am, input int pm, input bit early);
    clear_mon();
    exp_rows = nrows; exp_cols = ncols;
    acc_mode = am; pix_mode = pm; stall_done = 1'b0;
    job_complete = early;
    @(posedge clk_if); #2;
    host_start = 1'b1;
    num_cfg_words = CAW'(ncfg); num_rows = 10'(nrows); num_cols = 10'(ncols);
    @(posedge clk_if); #2;
    host_start = 1'b0;
    check("busy_after_start", vec_t'({host_busy, host_done}), vec_t'(2'b10));
  endtask

  task automatic finish_job(input int ncfg, input int nrows, input int ncols, input bit early);
    int i;
    for (i = 0; i < 20000 && n_done == 0; i++) begin
      @(posedge clk_if); #2;
      if (!early && n_fcmpl == nrows) job_complete = 1'b1;
    end
    check("done_seen", vec_t'(n_done != 0), vec_t'(1));
    job_complete = 1'b0;
    @(posedge clk_if); #2;
    check("busy_dropped", vec_t'({host_busy, host_done}), vec_t'(2'b00));
    check("cfg_nrd", vec_t'(cfg_addr_q.size()), vec_t'(ncfg));
    for (int k = 0; k < cfg_addr_q.size() && k < ncfg; k++) check("cfg_addr", vec_t'(cfg_addr_q[k]), vec_t'(k));
    check("cfg_nbeat", vec_t'(cfg_dat_q.size()), vec_t'(ncfg));
    for (int k = 0; k < cfg_dat_q.size() && k < ncfg; k++) check("cfg_data", vec_t'(cfg_dat_q[k]), vec_t'(cfg_mem[k]));
    check("pix_nrd", vec_t'(pix_addr_q.size()), vec_t'(nrows * ncols));
    for (int k = 0; k < pix_addr_q.size() && k < nrows * ncols; k++) check("pix_addr", vec_t'(pix_addr_q[k]), vec_t'(k));
    check("pix_nbeat", vec_t'(pix_dat_q.size()), vec_t'(nrows * ncols));
    for (int k = 0; k < pix_dat_q.size() && k < nrows * ncols; k++) check("pix_data", vec_t'(pix_dat_q[k]), vec_t'(pix_mem[k]));
    check("n_job_start", vec_t'(n_start), vec_t'(1));
    check("n_fetch_ack", vec_t'(n_fack), vec_t'(nrows));
    check("n_fetch_cmpl", vec_t'(n_fcmpl), vec_t'(nrows));
    check("n_cmpl_ack", vec_t'(n_cack), vec_t'(1));
    check("n_host_done", vec_t'(n_done), vec_t'(1));
    check("n_host_err", vec_t'(n_err), vec_t'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < 1024; k++) cfg_mem[k] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 256; k++)  pix_mem[k] = {$urandom, $urandom, $urandom, $urandom};
    clear_mon();
    exp_rows = 0; exp_cols = 0;

    // reset state
    #3 check("reset_outputs", all_out, vec_t'(0));
    #9 rst = 1'b0;

    // 1: full-rate job
    start_job(512, 10, 10, 0, 0, 1'b0);
    finish_job(512, 10, 10, 1'b0);
    check("cfg_back_to_back", vec_t'(cfg_last - cfg_first), vec_t'(511));

    // 2: random config_accept and pixel_ready
    start_job(512, 3, 7, 1, 2, 1'b0);
    finish_job(512, 3, 7, 1'b0);

    // 3: 5-cycle pixel_ready stall presenting word 23
    start_job(4, 5, 10, 0, 1, 1'b0);
    finish_job(4, 5, 10, 1'b0);
    check("stall_happened", vec_t'(stall_done), vec_t'(1));

    // 4: job_complete held high from the start of the job
    start_job(3, 10, 10, 0, 0, 1'b1);
    finish_job(3, 10, 10, 1'b1);

    // 5: reset while streaming row 4, then a fresh small job
    start_job(8, 10, 10, 0, 0, 1'b0);
    begin
      int i;
      for (i = 0; i < 5000 && !(n_fcmpl == 3 && pix_dat_q.size() >= 33); i++) @(posedge clk_if);
      check("reached_row4", vec_t'(n_fcmpl == 3 && pix_dat_q.size() >= 33), vec_t'(1));
    end
    #3 rst = 1'b1;
    #1 check("midjob_reset_outputs", all_out, vec_t'(0));
    repeat (2) @(posedge clk_if);
    #3 rst = 1'b0;
    start_job(5, 2, 3, 0, 0, 1'b0);
    finish_job(5, 2, 3, 1'b0);

    // 6: zero column count -> error completion, no quad traffic
    start_job(8, 4, 0, 0, 0, 1'b0);
    @(posedge clk_if); #1;
    check("err_done_pulse", vec_t'({host_done, host_err, host_busy}), vec_t'(3'b111));
    @(posedge clk_if); #1;
    check("err_done_end", vec_t'({host_done, host_err, host_busy}), vec_t'(3'b000));
    check("err_no_cfg_valid", vec_t'(n_cfg_valid), vec_t'(0));
    check("err_no_job_start", vec_t'(n_start), vec_t'(0));
    check("err_no_reads", vec_t'(cfg_addr_q.size() + pix_addr_q.size()), vec_t'(0));
    check("err_done_count", vec_t'({n_done, n_err}), vec_t'({32'd1, 32'd1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
